// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared widths, one-hot codes, register offsets and FSM states for int_ctrl
package int_ctrl_pkg;

    localparam int INT_BUS = 8;

    localparam logic [INT_BUS-1:0] INT_NONE     = 8'h00;
    localparam logic [INT_BUS-1:0] INT_TIMER    = 8'h01;
    localparam logic [INT_BUS-1:0] INT_UART_REV = 8'h02;

    localparam logic [3:0] REG_PENDING = 4'h0;
    localparam logic [3:0] REG_ENABLE  = 4'h4;
    localparam logic [3:0] REG_MODE    = 4'h8;
    localparam logic [3:0] REG_CLAIM   = 4'hC;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ASSERT     = 2'd1;
    localparam logic [1:0] ST_WAIT_ENTRY = 2'd2;
    localparam logic [1:0] ST_HANDLER    = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-wins priority encoder (valid + index)
module int_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last assignment and wins
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - machine-level interrupt controller feeding the CLINT trap sequencer
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = INT_BUS,
    parameter int ADDR_W  = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               mstatus_mie_i,
    input  logic               clint_busy_i,
    input  logic               clint_int_flag_i,
    output logic [NUM_SRC-1:0] int_flag_o,
    input  logic               reg_wen_i,
    input  logic [ADDR_W-1:0]  reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               in_service_o
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] r_src_prev;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_en;
    logic [NUM_SRC-1:0] r_mode;
    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_SRC-1:0] r_flag;
    logic [31:0]        r_rdata;

    logic [NUM_SRC-1:0] w_cand;
    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic               w_sel_pend;
    logic               w_sel_en;
    logic               w_sel_mode;
    logic               w_sel_claim;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_acc_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic               w_keep;
    logic               w_accept;
    logic               w_idx_valid;
    logic [7:0]         w_claim_idx;
    logic               w_unused;

    assign w_unused = &{1'b0, reg_wdata_i[31:NUM_SRC]};

    assign w_sel_pend  = (reg_addr_i == ADDR_W'(REG_PENDING));
    assign w_sel_en    = (reg_addr_i == ADDR_W'(REG_ENABLE));
    assign w_sel_mode  = (reg_addr_i == ADDR_W'(REG_MODE));
    assign w_sel_claim = (reg_addr_i == ADDR_W'(REG_CLAIM));

    assign w_cand = r_pend & r_en;

    int_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req   (w_cand),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Acceptance only counts while the latched source is still a candidate and MIE is set
    assign w_keep   = w_cand[r_idx] && mstatus_mie_i;
    assign w_accept = (r_state == ST_ASSERT) && w_keep && clint_busy_i;

    // Edge bits: new rising edge beats any clear; level bits simply follow the source
    always_comb begin
        w_rise     = src_i & ~r_src_prev;
        w_w1c      = (reg_wen_i && w_sel_pend) ? reg_wdata_i[NUM_SRC-1:0] : '0;
        w_acc_clr  = w_accept ? (NUM_SRC'(1) << r_idx) : '0;
        w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_w1c & ~w_acc_clr)))
                   | (~r_mode & src_i);
    end

    // Source history, pending bits and software-writable configuration
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_src_prev <= '0;
            r_pend     <= '0;
            r_en       <= '0;
            r_mode     <= '1;
        end else begin
            r_src_prev <= src_i;
            r_pend     <= w_pend_nxt;
            if (reg_wen_i && w_sel_en) begin
                r_en <= reg_wdata_i[NUM_SRC-1:0];
            end
            if (reg_wen_i && w_sel_mode) begin
                r_mode <= reg_wdata_i[NUM_SRC-1:0];
            end
        end
    end

    // Request/handshake sequencer: one interrupt in flight from latch until MRET
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_flag  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && mstatus_mie_i) begin
                        r_idx   <= w_idx;
                        r_flag  <= NUM_SRC'(1) << w_idx;
                        r_state <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (!w_keep) begin
                        r_flag  <= '0;
                        r_state <= ST_IDLE;
                    end else if (clint_busy_i) begin
                        r_flag  <= '0;
                        r_state <= ST_WAIT_ENTRY;
                    end
                end
                ST_WAIT_ENTRY: begin
                    if (clint_int_flag_i) begin
                        r_state <= ST_HANDLER;
                    end
                end
                ST_HANDLER: begin
                    if (clint_int_flag_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_flag  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_service_o = (r_state == ST_WAIT_ENTRY) || (r_state == ST_HANDLER);
    assign w_idx_valid  = (r_state != ST_IDLE);
    assign w_claim_idx  = w_idx_valid ? 8'(r_idx) : 8'hFF;

    // Registered read port; reflects register contents before any same-cycle write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
        end else if (w_sel_pend) begin
            r_rdata <= 32'(r_pend);
        end else if (w_sel_en) begin
            r_rdata <= 32'(r_en);
        end else if (w_sel_mode) begin
            r_rdata <= 32'(r_mode);
        end else if (w_sel_claim) begin
            r_rdata <= {in_service_o, 23'b0, w_claim_idx};
        end else begin
            r_rdata <= '0;
        end
    end

    assign int_flag_o  = r_flag;
    assign reg_rdata_o = r_rdata;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  src_i;
    logic        mstatus_mie_i;
    logic        clint_busy_i;
    logic        clint_int_flag_i;
    logic [7:0]  int_flag_o;
    logic        reg_wen_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        in_service_o;

    int n_cmp = 0;
    int n_err = 0;

    int_ctrl #(.NUM_SRC(8), .ADDR_W(4)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .src_i            (src_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .clint_busy_i     (clint_busy_i),
        .clint_int_flag_i (clint_int_flag_i),
        .int_flag_o       (int_flag_o),
        .reg_wen_i        (reg_wen_i),
        .reg_addr_i       (reg_addr_i),
        .reg_wdata_i      (reg_wdata_i),
        .reg_rdata_o      (reg_rdata_o),
        .in_service_o     (in_service_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        reg_wen_i   = 1'b1;
        reg_addr_i  = a;
        reg_wdata_i = d;
        tick();
        reg_wen_i   = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        reg_addr_i = a;
        tick();
        chk(tag, reg_rdata_o, exp);
    endtask

    task automatic clint_pulse();
        clint_int_flag_i = 1'b1;
        tick();
        clint_int_flag_i = 1'b0;
    endtask

    task automatic accept_and_return();
        clint_busy_i = 1'b1;
        tick();
        clint_busy_i = 1'b0;
        clint_pulse();
        clint_pulse();
    endtask

    initial begin
        rst_n_i          = 1'b0;
        src_i            = '0;
        mstatus_mie_i    = 1'b0;
        clint_busy_i     = 1'b0;
        clint_int_flag_i = 1'b0;
        reg_wen_i        = 1'b0;
        reg_addr_i       = 4'h0;
        reg_wdata_i      = '0;
        tick();
        tick();
        chk("rst_flag", 32'(int_flag_o), 32'h0);
        chk("rst_rdata", reg_rdata_o, 32'h0);
        chk("rst_insvc", 32'(in_service_o), 32'h0);
        rst_n_i = 1'b1;
        reg_read(4'h8, 32'h0000_00FF, "rst_mode");

        // write returns pre-write value, then new value; unmapped offset reads 0
        reg_write(4'h4, 32'h0000_0003);
        chk("wr_prewrite", reg_rdata_o, 32'h0);
        reg_read(4'h4, 32'h0000_0003, "enable_rd");
        reg_write(4'h1, 32'h0000_00FF);
        reg_read(4'h1, 32'h0, "bad_offset");
        reg_read(4'h4, 32'h0000_0003, "bad_wr_ignored");

        // uart_rev edge pulse through the full handshake
        mstatus_mie_i = 1'b1;
        src_i = 8'h02;
        tick();
        src_i = 8'h00;
        chk("t1_flag_latency", 32'(int_flag_o), 32'h0);
        tick();
        chk("t1_flag", 32'(int_flag_o), 32'h02);
        clint_busy_i = 1'b1;
        tick();
        clint_busy_i = 1'b0;
        chk("t1_flag_accept", 32'(int_flag_o), 32'h0);
        chk("t1_insvc_wait", 32'(in_service_o), 32'h1);
        reg_read(4'h0, 32'h0, "t1_pend_cleared");
        clint_pulse();
        chk("t1_insvc_handler", 32'(in_service_o), 32'h1);
        clint_pulse();
        chk("t1_insvc_idle", 32'(in_service_o), 32'h0);
        clint_pulse();
        chk("idle_pulse_ignored", 32'(in_service_o), 32'h0);

        // simultaneous edges: timer wins, uart follows after MRET
        src_i = 8'h03;
        tick();
        src_i = 8'h00;
        tick();
        chk("t2_timer_first", 32'(int_flag_o), 32'h01);
        accept_and_return();
        tick();
        chk("t2_uart_second", 32'(int_flag_o), 32'h02);
        accept_and_return();

        // withdraw on MIE drop leaves pending intact, re-asserts when MIE returns
        src_i = 8'h01;
        tick();
        src_i = 8'h00;
        tick();
        chk("t3_assert", 32'(int_flag_o), 32'h01);
        mstatus_mie_i = 1'b0;
        tick();
        chk("t3_withdrawn", 32'(int_flag_o), 32'h0);
        reg_read(4'h0, 32'h01, "t3_pend_kept");
        mstatus_mie_i = 1'b1;
        tick();
        chk("t3_reassert", 32'(int_flag_o), 32'h01);
        accept_and_return();

        // level mode on timer: held source re-asserts right after MRET, W1C ineffective
        reg_write(4'h8, 32'h0000_00FE);
        src_i = 8'h01;
        tick();
        tick();
        chk("t4_level_assert", 32'(int_flag_o), 32'h01);
        accept_and_return();
        tick();
        chk("t4_level_reassert", 32'(int_flag_o), 32'h01);
        reg_write(4'h0, 32'h0000_0001);
        reg_read(4'h0, 32'h01, "t4_w1c_noeffect");
        mstatus_mie_i = 1'b0;
        src_i = 8'h00;
        tick();
        reg_write(4'h8, 32'h0000_00FF);
        mstatus_mie_i = 1'b1;

        // edge set beats same-cycle W1C; CLAIM inside handler
        reg_write(4'h4, 32'h0000_0007);
        src_i       = 8'h04;
        reg_wen_i   = 1'b1;
        reg_addr_i  = 4'h0;
        reg_wdata_i = 32'h0000_0004;
        tick();
        reg_wen_i = 1'b0;
        src_i     = 8'h00;
        reg_read(4'h0, 32'h04, "t5_set_wins");
        chk("t5_flag", 32'(int_flag_o), 32'h04);
        clint_busy_i = 1'b1;
        tick();
        clint_busy_i = 1'b0;
        clint_pulse();
        reg_read(4'hC, 32'h8000_0002, "t5_claim_handler");

        // reset mid-handler abandons the handshake
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        chk("t6_flag", 32'(int_flag_o), 32'h0);
        chk("t6_rdata", reg_rdata_o, 32'h0);
        chk("t6_insvc", 32'(in_service_o), 32'h0);
        reg_read(4'h4, 32'h0, "t6_enable");
        reg_read(4'hC, 32'h0000_00FF, "t6_claim_idle");
        reg_read(4'h0, 32'h0, "t6_pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
